// File: rtl/seq_lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_lock_ctrl_if
// Bundles the serial-code input stream and the lock status outputs of
// seq_lock_ctrl.
//   master : access-control side, drives seq_valid/seq/relock, reads status
//   slave  : lock controller, reads the stream, drives status
// Signals:
//   seq_valid  qualifies seq
//   seq        serial code bit, MSB of the code first
//   relock     return to LOCKED / abort the partial attempt
//   state      2'b01 LOCKED, 2'b00 UNLOCKED, 2'b10 LOCKOUT
//   det/error  1-cycle match / mismatch pulses
//   tries_left failed attempts remaining before lockout
//   bit_cnt    bits collected in the current attempt
// ---------------------------------------------------------------------------
interface seq_lock_ctrl_if #(
  parameter int CODE_LEN  = 4,
  parameter int MAX_TRIES = 3
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic             seq_valid;
  logic             seq;
  logic             relock;
  logic [1:0]       state;
  logic             det;
  logic             error;
  logic [TRY_W-1:0] tries_left;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output seq_valid, seq, relock,
    input  state, det, error, tries_left, bit_cnt
  );

  modport slave (
    input  seq_valid, seq, relock,
    output state, det, error, tries_left, bit_cnt
  );
endinterface

// File: rtl/seq_lock_ctrl.sv
// ---------------------------------------------------------------------------
// seq_lock_ctrl
// Serial keypad-lock controller. Collects CODE_LEN-bit attempts from a
// qualified bit stream, compares each complete attempt with CODE, counts
// consecutive failures and enters a timed lockout after MAX_TRIES of them.
// Ports:
//   clock       system clock, rising edge
//   resetphase  asynchronous, active-high reset
//   bus         seq_lock_ctrl_if.slave (stream in, registered status out)
// ---------------------------------------------------------------------------
module seq_lock_ctrl #(
  parameter int                  CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0] CODE        = 4'b1011,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  LOCKOUT_CYC = 16
) (
  input logic            clock,
  input logic            resetphase,
  seq_lock_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(LOCKOUT_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CODE_LEN - 1);
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_LOCKED   = 2'b01,
    ST_LOCKOUT  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  // Only CODE_LEN-1 history bits are kept; the final bit of an attempt is
  // compared straight from the input on the edge that consumes it.
  logic [CODE_LEN-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                det_q, det_d;
  logic                error_q, error_d;
  logic [CODE_LEN-1:0] attempt;

  assign attempt = {shreg_q, bus.seq};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the shift register is reset too, since a partial
  // attempt must never survive a reset.
  always_ff @(posedge clock or posedge resetphase) begin
    if (resetphase) begin
      state_q   <= ST_LOCKED;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tries_q   <= TRIES_MAX;
      timer_q   <= '0;
      det_q     <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      det_q     <= det_d;
      error_q   <= error_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    det_d     = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      ST_LOCKED: begin
        if (bus.relock) begin
          // Abort: drop the partial attempt without charging a failure.
          bit_cnt_d = '0;
        end else if (bus.seq_valid) begin
          shreg_d = attempt[CODE_LEN-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (attempt == CODE) begin
              det_d   = 1'b1;
              state_d = ST_UNLOCKED;
              tries_d = TRIES_MAX;
            end else begin
              error_d = 1'b1;
              // Saturating decrement; reaching zero starts the lockout.
              if (tries_q <= TRY_W'(1)) begin
                tries_d = '0;
                state_d = ST_LOCKOUT;
                timer_d = TMR_LOAD;
              end else begin
                tries_d = tries_q - TRY_W'(1);
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_UNLOCKED: begin
        bit_cnt_d = '0;
        if (bus.relock) state_d = ST_LOCKED;
      end

      ST_LOCKOUT: begin
        // Timer loaded with LOCKOUT_CYC-1 and left on the edge it reads 0,
        // giving exactly LOCKOUT_CYC cycles in this state.
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          tries_d = TRIES_MAX;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        state_d   = ST_LOCKED;
        bit_cnt_d = '0;
        tries_d   = TRIES_MAX;
      end
    endcase
  end

  assign bus.state      = state_q;
  assign bus.det        = det_q;
  assign bus.error      = error_q;
  assign bus.tries_left = tries_q;
  assign bus.bit_cnt    = bit_cnt_q;

endmodule

// File: doc/seq_lock_ctrl.md
Name: seq_lock_ctrl

Overview:
Parametrised serial keypad-lock controller. It collects CODE_LEN-bit attempts from a qualified serial bit stream and compares each complete attempt with a programmable code. It counts failed attempts and enters a timed lockout after MAX_TRIES consecutive failures. It reports lock state, 1-cycle match/error pulses and remaining tries to the surrounding access-control logic.

Parameters:
CODE_LEN, 4, bits per attempt; legal range 2..16
CODE, 4'b1011, reference code, CODE_LEN bits wide; MSB is received first
MAX_TRIES, 3, consecutive failed attempts that trigger lockout; must be >= 1
LOCKOUT_CYC, 16, clock cycles spent in lockout; must be >= 1

Ports:
clock  in  1  system clock; all state updates on the rising edge
resetphase  in  1  reset, asynchronous, active-high
seq_valid  in  1  qualifies seq; a bit is consumed only when this is 1
seq  in  1  serial code bit
relock  in  1  request return to LOCKED / abort the current attempt
state  out  2  current lock state: 2'b01 LOCKED, 2'b00 UNLOCKED, 2'b10 LOCKOUT
det  out  1  1-cycle pulse: attempt matched CODE
error  out  1  1-cycle pulse: attempt mismatched CODE
tries_left  out  $clog2(MAX_TRIES+1)  failed attempts remaining before lockout
bit_cnt  out  $clog2(CODE_LEN+1)  bits collected in the current attempt

Behaviour:
- All outputs are registered. No combinational path from input to output.
- Reset (asynchronous, takes effect immediately):
  - state=LOCKED, det=0, error=0, tries_left=MAX_TRIES, bit_cnt=0.
  - Shift register and lockout timer cleared.
  - Reset asserted mid-attempt discards all partial bits.
- det and error default to 0 every cycle. They are never both 1 in the same cycle.
- LOCKED:
  - Each edge with seq_valid=1 shifts seq into the shift register (LSB in) and increments bit_cnt.
  - On the edge that consumes bit number CODE_LEN, compare {shreg[CODE_LEN-2:0], seq} with CODE. bit_cnt returns to 0.
  - Match: det=1 in the following cycle; state goes to UNLOCKED; tries_left reloads to MAX_TRIES.
  - Mismatch: error=1 in the following cycle; tries_left decrements. If the new value is 0, state goes to LOCKOUT and the timer loads LOCKOUT_CYC-1.
  - Attempts do not overlap. Each attempt is exactly CODE_LEN fresh bits; no sliding-window detection.
  - seq_valid=0 cycles are gaps. The partial attempt is held indefinitely.
  - relock=1 aborts the partial attempt: bit_cnt=0, the bit in that cycle is discarded, no failure is counted, tries_left is unchanged.
- UNLOCKED:
  - seq_valid/seq are ignored; bit_cnt stays 0.
  - relock=1 sets state to LOCKED on that edge. tries_left stays at MAX_TRIES.
- LOCKOUT:
  - seq_valid, seq and relock are ignored.
  - The timer decrements every edge. On the edge where the timer is 0: state goes to LOCKED and tries_left reloads to MAX_TRIES.
  - state reads 2'b10 for exactly LOCKOUT_CYC cycles.
- tries_left saturates: it never underflows below 0 and never exceeds MAX_TRIES.
- Unused state encoding 2'b11 recovers to LOCKED on the next edge, with bit_cnt=0 and tries_left=MAX_TRIES.

Test Plan:
1. Reset, then seq_valid=1 for four cycles with seq=1,0,1,1 -> cycle after the 4th bit: det=1 for 1 cycle, state=2'b00, tries_left=3, error stays 0.
2. From LOCKED send 1,1,1,1 -> error=1 for 1 cycle, tries_left=2, state=2'b01. Then send 1,0,1,1 -> det=1, state=2'b00, tries_left=3.
3. Three wrong attempts (0000 x3) -> tries_left 3,2,1,0; state=2'b10 for exactly 16 cycles; bits 1,0,1,1 sent during lockout are ignored (no det); then state=2'b01, tries_left=3.
4. Send 1,0 with seq_valid gaps of 5 cycles between the bits, then 1,1 -> det fires; bit_cnt reads 0,1,2,3 across the attempt.
5. Send 1,0 then pulse resetphase mid-cycle -> outputs reset immediately. Then send 1,1 -> no det/error and bit_cnt=2. Complete with 1,1 (attempt 1111) -> error=1.
6. In UNLOCKED assert relock with seq_valid=1 -> state=2'b01, bit_cnt=0. In LOCKED after 2 bits assert relock -> bit_cnt=0, tries_left unchanged, no error pulse.
